// File: rtl/serv_rf_ram_sched.sv
// Bridges the bit-serial register file ports onto a WIDTH-bit RAM: two read
// ports streamed LSB first with next-word prefetch, two deserialized write ports.
module serv_rf_ram_sched #(
  parameter  int WIDTH    = 8,
  parameter  int CSR_REGS = 4,
  localparam int AW       = $clog2(32 + CSR_REGS) + $clog2(32 / WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rreq,
  output logic             o_ready,
  input  logic             i_cnt_en,
  input  logic [5:0]       i_rreg0,
  input  logic [5:0]       i_rreg1,
  output logic             o_rdata0,
  output logic             o_rdata1,
  input  logic [5:0]       i_wreg0,
  input  logic [5:0]       i_wreg1,
  input  logic             i_wen0,
  input  logic             i_wen1,
  input  logic             i_wdata0,
  input  logic             i_wdata1,
  output logic [AW-1:0]    o_raddr,
  output logic             o_ren,
  input  logic [WIDTH-1:0] i_rdata,
  output logic [AW-1:0]    o_waddr,
  output logic [WIDTH-1:0] o_wdata,
  output logic             o_wen
);

  localparam int LW    = $clog2(WIDTH);
  localparam int WB    = $clog2(32 / WIDTH);
  localparam int WORDS = 32 / WIDTH;
  localparam logic [LW-1:0] IDX_PF    = LW'(WIDTH - 3);
  localparam logic [LW-1:0] IDX_LAST  = LW'(WIDTH - 1);
  localparam logic [AW-1:0] WMASK     = AW'((1 << WB) - 1);
  localparam logic [4:0]    LAST_WORD = 5'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t          state, state_nxt;
  logic            prime_ph;
  logic [4:0]      cnt;
  logic [LW-1:0]   idx;
  logic [4:0]      cur_word;
  logic            run_en, pf0, wrap, done, wlatch;
  logic            pf1, cap0, cap1;
  logic [WIDTH-1:0] sh0, sh1, nxt0, nxt1;
  logic [WIDTH-1:0] wsh0, wsh1, pw_data0, pw_data1;
  logic            pend0, pend1, pw_en0, pw_en1;
  logic [AW-1:0]   pw_addr0, pw_addr1;

  // Word index occupies the low WB bits; masking keeps WIDTH=32 to a pure register number.
  function automatic logic [AW-1:0] ram_addr(input logic [5:0] r, input logic [4:0] w);
    return (AW'(r) << WB) | (AW'(w) & WMASK);
  endfunction

  assign idx      = cnt[LW-1:0];
  assign cur_word = cnt >> LW;
  assign run_en   = (state == RUN) && i_cnt_en;
  // Prefetch fires on the step into index WIDTH-2 so both next words land before the wrap.
  assign pf0      = run_en && (idx == IDX_PF) && (cur_word != LAST_WORD);
  assign wrap     = run_en && (idx == IDX_LAST);
  assign wlatch   = wrap;
  assign done     = run_en && (cnt == 5'd31);

  assign o_rdata0 = sh0[0];
  assign o_rdata1 = sh1[0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      prime_ph <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      prime_ph <= (state == PRIME) && !prime_ph;
      if (run_en) cnt <= cnt + 5'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    o_ren     = 1'b0;
    o_raddr   = '0;
    o_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (i_rreq) begin
          o_ren     = 1'b1;
          o_raddr   = ram_addr(i_rreg0, 5'd0);
          state_nxt = PRIME;
        end
      end
      PRIME: begin
        if (!prime_ph) begin
          o_ren   = 1'b1;
          o_raddr = ram_addr(i_rreg1, 5'd0);
        end else begin
          o_ready   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (pf0) begin
          o_ren   = 1'b1;
          o_raddr = ram_addr(i_rreg0, cur_word + 5'd1);
        end else if (pf1) begin
          o_ren   = 1'b1;
          o_raddr = ram_addr(i_rreg1, cur_word + 5'd1);
        end
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Port1's prefetch data can arrive on the very wrap cycle, hence the bypass.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pf1  <= 1'b0;
      cap0 <= 1'b0;
      cap1 <= 1'b0;
      sh0  <= '0;
      sh1  <= '0;
      nxt0 <= '0;
      nxt1 <= '0;
    end else begin
      pf1  <= pf0;
      cap0 <= pf0;
      cap1 <= pf1;
      if (state == PRIME && !prime_ph) sh0 <= i_rdata;
      else if (wrap)                   sh0 <= nxt0;
      else if (run_en)                 sh0 <= sh0 >> 1;
      if (state == PRIME && prime_ph)  sh1 <= i_rdata;
      else if (wrap)                   sh1 <= cap1 ? i_rdata : nxt1;
      else if (run_en)                 sh1 <= sh1 >> 1;
      if (cap0) nxt0 <= i_rdata;
      if (cap1) nxt1 <= i_rdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wsh0     <= '0;
      wsh1     <= '0;
      pend0    <= 1'b0;
      pend1    <= 1'b0;
      pw_en0   <= 1'b0;
      pw_en1   <= 1'b0;
      pw_addr0 <= '0;
      pw_addr1 <= '0;
      pw_data0 <= '0;
      pw_data1 <= '0;
    end else begin
      if (run_en) begin
        wsh0 <= {i_wdata0, wsh0[WIDTH-1:1]};
        wsh1 <= {i_wdata1, wsh1[WIDTH-1:1]};
      end
      if (wlatch) begin
        pend0    <= 1'b1;
        pend1    <= 1'b1;
        pw_en0   <= i_wen0;
        pw_en1   <= i_wen1;
        pw_addr0 <= ram_addr(i_wreg0, cur_word);
        pw_addr1 <= ram_addr(i_wreg1, cur_word);
        pw_data0 <= {i_wdata0, wsh0[WIDTH-1:1]};
        pw_data1 <= {i_wdata1, wsh1[WIDTH-1:1]};
      end else if (pend0) begin
        pend0 <= 1'b0;
      end else if (pend1) begin
        pend1 <= 1'b0;
      end
    end
  end

  // Port0 always goes first; port1 waits out exactly that one cycle.
  always_comb begin
    o_wen   = 1'b0;
    o_waddr = '0;
    o_wdata = '0;
    if (pend0) begin
      o_wen   = pw_en0;
      o_waddr = pw_addr0;
      o_wdata = pw_data0;
    end else if (pend1) begin
      o_wen   = pw_en1;
      o_waddr = pw_addr1;
      o_wdata = pw_data1;
    end
  end

endmodule

// File: tb/tb_serv_rf_ram_sched.sv
// Scoreboard bench: a WIDTH=8 and a WIDTH=32 instance run in lockstep on the
// same serial stimulus, each backed by its own behavioural RAM.
module tb_serv_rf_ram_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rreq = 1'b0, cnt_en = 1'b0;
  logic [5:0] rreg0 = '0, rreg1 = '0, wreg0 = '0, wreg1 = '0;
  logic wen0 = 1'b0, wen1 = 1'b0, wdata0 = 1'b0, wdata1 = 1'b0;

  logic rdy8, rd0_8, rd1_8, ren8, wen8;
  logic [7:0] raddr8, waddr8, wdata8;
  logic [7:0] rdata8 = '0;
  logic rdy32, rd0_32, rd1_32, ren32, wen32;
  logic [5:0] raddr32, waddr32;
  logic [31:0] wdata32;
  logic [31:0] rdata32 = '0;

  logic [7:0]  mem8  [0:255];
  logic [31:0] mem32 [0:63];

  logic s_ren8, s_wen8, s_ren32, s_wen32;
  logic [7:0] s_raddr8, s_waddr8, s_wdata8;
  logic [5:0] s_raddr32, s_waddr32;
  logic [31:0] s_wdata32;

  int checks = 0, errors = 0;
  int ren8_cnt = 0, ren32_cnt = 0, wen8_cnt = 0, wen32_cnt = 0;
  logic q0[$], q1[$];
  logic [63:0] wq8[$], wq32[$];

  always #5 clk = ~clk;

  serv_rf_ram_sched #(.WIDTH(8), .CSR_REGS(4)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rreq(rreq), .o_ready(rdy8), .i_cnt_en(cnt_en),
    .i_rreg0(rreg0), .i_rreg1(rreg1), .o_rdata0(rd0_8), .o_rdata1(rd1_8),
    .i_wreg0(wreg0), .i_wreg1(wreg1), .i_wen0(wen0), .i_wen1(wen1),
    .i_wdata0(wdata0), .i_wdata1(wdata1), .o_raddr(raddr8), .o_ren(ren8),
    .i_rdata(rdata8), .o_waddr(waddr8), .o_wdata(wdata8), .o_wen(wen8));

  serv_rf_ram_sched #(.WIDTH(32), .CSR_REGS(4)) u_dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rreq(rreq), .o_ready(rdy32), .i_cnt_en(cnt_en),
    .i_rreg0(rreg0), .i_rreg1(rreg1), .o_rdata0(rd0_32), .o_rdata1(rd1_32),
    .i_wreg0(wreg0), .i_wreg1(wreg1), .i_wen0(wen0), .i_wen1(wen1),
    .i_wdata0(wdata0), .i_wdata1(wdata1), .o_raddr(raddr32), .o_ren(ren32),
    .i_rdata(rdata32), .o_waddr(waddr32), .o_wdata(wdata32), .o_wen(wen32));

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Outputs are sampled mid-cycle; the RAMs act on those samples just after the next edge.
  always @(negedge clk) begin
    s_ren8 = ren8;   s_raddr8 = raddr8;   s_wen8 = wen8;   s_waddr8 = waddr8;   s_wdata8 = wdata8;
    s_ren32 = ren32; s_raddr32 = raddr32; s_wen32 = wen32; s_waddr32 = waddr32; s_wdata32 = wdata32;
    if (ren8) ren8_cnt++;
    if (ren32) ren32_cnt++;
    if (wen8) begin
      wen8_cnt++;
      if (wq8.size() == 0) checkOutput("wr8_unexpected", 64'({wen8, waddr8, wdata8}), 64'(0));
      else checkOutput("wr8", 64'({waddr8, wdata8}), wq8.pop_front());
    end
    if (wen32) begin
      wen32_cnt++;
      if (wq32.size() == 0) checkOutput("wr32_unexpected", 64'({wen32, waddr32, wdata32}), 64'(0));
      else checkOutput("wr32", 64'({waddr32, wdata32}), wq32.pop_front());
    end
  end

  always @(posedge clk) begin
    #1;
    if (s_ren8)  rdata8 = mem8[s_raddr8];
    if (s_wen8)  mem8[s_waddr8] = s_wdata8;
    if (s_ren32) rdata32 = mem32[s_raddr32];
    if (s_wen32) mem32[s_waddr32] = s_wdata32;
  end

  task automatic loadReg(input int r, input logic [31:0] v);
    for (int w = 0; w < 4; w++) mem8[r*4 + w] = v[8*w +: 8];
    mem32[r] = v;
  endtask

  task automatic applyStimulus(input logic [5:0] r0, input logic [5:0] r1,
                               input logic [31:0] v0, input logic [31:0] v1,
                               input logic we0, input logic we1,
                               input logic [5:0] wr0, input logic [5:0] wr1,
                               input logic [31:0] wv0, input logic [31:0] wv1,
                               input int gap_a, input int gap_b, input int rst_at);
    int ren8_s, ren32_s, wen8_s, wen32_s, exp_w8, exp_w32;
    logic b0, b1;
    for (int i = 0; i < 32; i++) begin
      q0.push_back(v0[i]);
      q1.push_back(v1[i]);
    end
    exp_w8 = 0;
    exp_w32 = 0;
    for (int w = 0; w < 4; w++) begin
      if (we0) begin wq8.push_back(64'({8'(wr0*4 + w), wv0[8*w +: 8]})); exp_w8++; end
      if (we1) begin wq8.push_back(64'({8'(wr1*4 + w), wv1[8*w +: 8]})); exp_w8++; end
    end
    if (we0) begin wq32.push_back(64'({wr0, wv0})); exp_w32++; end
    if (we1) begin wq32.push_back(64'({wr1, wv1})); exp_w32++; end
    ren8_s = ren8_cnt; ren32_s = ren32_cnt; wen8_s = wen8_cnt; wen32_s = wen32_cnt;

    @(posedge clk); #1;
    rreg0 = r0; rreg1 = r1; wreg0 = wr0; wreg1 = wr1; wen0 = we0; wen1 = we1; rreq = 1'b1;
    @(negedge clk);
    checkOutput("ren8_t0", 64'({ren8, raddr8}), 64'({1'b1, 8'(r0*4)}));
    checkOutput("ren32_t0", 64'({ren32, raddr32}), 64'({1'b1, r0}));
    @(posedge clk); #1 rreq = 1'b0;
    @(negedge clk);
    checkOutput("ren8_t1", 64'({ren8, raddr8}), 64'({1'b1, 8'(r1*4)}));
    checkOutput("ren32_t1", 64'({ren32, raddr32}), 64'({1'b1, r1}));
    checkOutput("ready_t1", 64'({rdy8, rdy32}), 64'(2'b00));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("ready_t2", 64'({rdy8, rdy32}), 64'(2'b11));

    for (int b = 0; b < 32; b++) begin
      if (b == rst_at) begin
        @(posedge clk); #2 rst_n = 1'b0; cnt_en = 1'b0;
        #1;
        checkOutput("rst_outs8", 64'({rdy8, ren8, raddr8, rd0_8, rd1_8, wen8, waddr8, wdata8}), 64'(0));
        checkOutput("rst_outs32", 64'({rdy32, ren32, raddr32, rd0_32, rd1_32, wen32, waddr32, wdata32}), 64'(0));
        q0.delete(); q1.delete(); wq8.delete(); wq32.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wen8_s = wen8_cnt; wen32_s = wen32_cnt;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("no_wen_after_rst", 64'(wen8_cnt - wen8_s + wen32_cnt - wen32_s), 64'(0));
        return;
      end
      if (b == gap_a || b == gap_b) repeat (3) begin
        @(posedge clk); #1 cnt_en = 1'b0;
      end
      @(posedge clk); #1;
      cnt_en = 1'b1; wdata0 = wv0[b]; wdata1 = wv1[b];
      @(negedge clk);
      b0 = q0.pop_front();
      b1 = q1.pop_front();
      checkOutput($sformatf("rd0_bit%0d", b), 64'({rd0_8, rd0_32}), 64'({b0, b0}));
      checkOutput($sformatf("rd1_bit%0d", b), 64'({rd1_8, rd1_32}), 64'({b1, b1}));
    end
    @(posedge clk); #1;
    cnt_en = 1'b0; wdata0 = 1'b0; wdata1 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("ren8_count", 64'(ren8_cnt - ren8_s), 64'(8));
    checkOutput("ren32_count", 64'(ren32_cnt - ren32_s), 64'(2));
    checkOutput("wen8_count", 64'(wen8_cnt - wen8_s), 64'(exp_w8));
    checkOutput("wen32_count", 64'(wen32_cnt - wen32_s), 64'(exp_w32));
    checkOutput("wq_left", 64'(wq8.size() + wq32.size()), 64'(0));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem8[i] = '0;
    for (int i = 0; i < 64; i++) mem32[i] = '0;
    loadReg(5, 32'hA5A5_0F0F);
    loadReg(6, 32'h1234_5678);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset8", 64'({rdy8, ren8, raddr8, rd0_8, rd1_8, wen8, waddr8, wdata8}), 64'(0));
    checkOutput("reset32", 64'({rdy32, ren32, raddr32, rd0_32, rd1_32, wen32, waddr32, wdata32}), 64'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] contiguous read of reg5/reg6");
    applyStimulus(6'd5, 6'd6, 32'hA5A5_0F0F, 32'h1234_5678, 1'b0, 1'b0, 6'd0, 6'd0, 32'h0, 32'h0, -1, -1, -1);
    $display("[TB] read with cnt_en gaps at bits 6 and 15");
    applyStimulus(6'd5, 6'd6, 32'hA5A5_0F0F, 32'h1234_5678, 1'b0, 1'b0, 6'd0, 6'd0, 32'h0, 32'h0, 6, 15, -1);
    $display("[TB] dual-port write to reg7/reg33");
    applyStimulus(6'd5, 6'd6, 32'hA5A5_0F0F, 32'h1234_5678, 1'b1, 1'b1, 6'd7, 6'd33, 32'hDEAD_BEEF, 32'h0000_0100, -1, -1, -1);
    $display("[TB] readback reg7/reg33, port0-only write to reg8");
    applyStimulus(6'd7, 6'd33, 32'hDEAD_BEEF, 32'h0000_0100, 1'b1, 1'b0, 6'd8, 6'd0, 32'hCAFE_F00D, 32'h0, 3, -1, -1);
    $display("[TB] reset at bit 12 of RUN");
    applyStimulus(6'd8, 6'd5, 32'hCAFE_F00D, 32'hA5A5_0F0F, 1'b1, 1'b1, 6'd9, 6'd10, 32'h1111_1111, 32'h2222_2222, -1, -1, 12);
    $display("[TB] access after reset");
    applyStimulus(6'd8, 6'd6, 32'hCAFE_F00D, 32'h1234_5678, 1'b0, 1'b0, 6'd0, 6'd0, 32'h0, 32'h0, -1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
